// File: rtl/sha_padder.sv
// sha_padder: FIPS 180-4 message padder and block former feeding sha_engine.
// Bytes are packed big-endian into a 512- or 1024-bit block. The 0x80 marker
// and the bit-length field are added, and each block is handed over on a
// valid/ready handshake.

package sha;
  typedef enum logic [2:0] {
    sha1       = 3'd0,
    sha224     = 3'd1,
    sha256     = 3'd2,
    sha384     = 3'd3,
    sha512     = 3'd4,
    sha512_224 = 3'd5,
    sha512_256 = 3'd6
  } mode_t;
endpackage

module sha_padder #(
  parameter int BYTE_CNT_W = 61
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [7:0]    in_data,
  input  logic          in_last,
  input  sha::mode_t    in_mode,
  output logic          out_new_msg,
  output logic          out_valid,
  output sha::mode_t    out_mode,
  output logic [1023:0] out_msg,
  input  logic          out_ready,
  output logic          msg_done
);

  typedef enum logic [1:0] {ST_IDLE, ST_FILL, ST_SEND, ST_GAP} state_t;
  typedef enum logic [1:0] {PEND_NONE, PEND_LEN, PEND_MARK} pend_t;

  // 1024-bit block modes use 128-byte blocks; the rest use 64-byte blocks.
  function automatic logic is_big(input sha::mode_t m);
    case (m)
      sha::sha384, sha::sha512, sha::sha512_224, sha::sha512_256: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // OR byte b into block position idx (byte 0 is the most significant byte of the block).
  function automatic logic [1023:0] put_byte(input logic [1023:0] blk, input logic [7:0] idx,
                                             input logic [7:0] b, input logic big);
    logic [10:0] sh;
    sh = (big ? 11'd1016 : 11'd504) - {idx, 3'b000};
    return blk | ({1016'd0, b} << sh);
  endfunction

  state_t                state_r, state_s;
  pend_t                 pend_r, pend_s;
  sha::mode_t            mode_r, mode_s, cur_mode_s;
  logic [1023:0]         buf_r, buf_s, cur_buf_s, filled_s;
  logic [BYTE_CNT_W-1:0] cnt_r, cnt_s, cnt_inc_s;
  logic [7:0]            idx_r, idx_s, cur_idx_s, t_s, bsize_s, lsize_s;
  logic [63:0]           len_r, len_s, msg_len_s;
  logic                  first_r, first_s, final_r, final_s, open_r, open_s;
  logic                  start_s, big_s, accept_s, in_ready_s;
  logic                  out_valid_r, out_new_msg_r, msg_done_r, msg_done_s;
  sha::mode_t            out_mode_r;
  logic [1023:0]         out_msg_r;

  assign in_ready_s  = ~rst & ((state_r == ST_IDLE) | (state_r == ST_FILL));
  assign in_ready    = in_ready_s;
  assign accept_s    = in_valid & in_ready_s;
  assign out_valid   = out_valid_r;
  assign out_new_msg = out_new_msg_r;
  assign out_mode    = out_mode_r;
  assign out_msg     = out_msg_r;
  assign msg_done    = msg_done_r;

  // Block under construction after the byte offered this cycle is written.
  always_comb begin
    start_s    = (state_r == ST_IDLE);
    cur_mode_s = start_s ? in_mode : mode_r;
    big_s      = is_big(cur_mode_s);
    bsize_s    = big_s ? 8'd128 : 8'd64;
    lsize_s    = big_s ? 8'd16 : 8'd8;
    cur_idx_s  = start_s ? 8'd0 : idx_r;
    cur_buf_s  = start_s ? 1024'd0 : buf_r;
    cnt_inc_s  = (start_s ? {BYTE_CNT_W{1'b0}} : cnt_r) + BYTE_CNT_W'(1'b1);
    t_s        = cur_idx_s + 8'd1;
    filled_s   = put_byte(cur_buf_s, cur_idx_s, in_data, big_s);
    msg_len_s  = 64'({cnt_inc_s, 3'b000});
  end

  // Next-state and next-output logic.
  always_comb begin
    state_s    = state_r;
    pend_s     = pend_r;
    mode_s     = mode_r;
    buf_s      = buf_r;
    cnt_s      = cnt_r;
    idx_s      = idx_r;
    len_s      = len_r;
    first_s    = first_r;
    final_s    = final_r;
    open_s     = open_r;
    msg_done_s = 1'b0;
    case (state_r)
      ST_IDLE, ST_FILL: begin
        if (accept_s) begin
          mode_s  = cur_mode_s;
          cnt_s   = cnt_inc_s;
          first_s = start_s ? 1'b1 : first_r;
          if (!in_last) begin
            open_s = 1'b1;
            buf_s  = filled_s;
            if (t_s == bsize_s) begin
              state_s = ST_SEND;
              idx_s   = 8'd0;
              pend_s  = PEND_NONE;
              final_s = 1'b0;
            end else begin
              state_s = ST_FILL;
              idx_s   = t_s;
            end
          end else begin
            open_s  = 1'b0;
            state_s = ST_SEND;
            idx_s   = 8'd0;
            len_s   = msg_len_s;
            if (t_s <= bsize_s - lsize_s - 8'd1) begin
              buf_s   = put_byte(filled_s, t_s, 8'h80, big_s) | {960'd0, msg_len_s};
              pend_s  = PEND_NONE;
              final_s = 1'b1;
            end else if (t_s < bsize_s) begin
              buf_s   = put_byte(filled_s, t_s, 8'h80, big_s);
              pend_s  = PEND_LEN;
              final_s = 1'b0;
            end else begin
              buf_s   = filled_s;
              pend_s  = PEND_MARK;
              final_s = 1'b0;
            end
          end
        end else begin
          state_s = state_r;
        end
      end
      ST_SEND: begin
        if (out_ready) begin
          state_s    = ST_GAP;
          first_s    = 1'b0;
          msg_done_s = final_r;
        end else begin
          state_s = ST_SEND;
        end
      end
      ST_GAP: begin
        if (pend_r != PEND_NONE) begin
          if (pend_r == PEND_MARK) begin
            buf_s = put_byte(1024'd0, 8'd0, 8'h80, is_big(mode_r)) | {960'd0, len_r};
          end else begin
            buf_s = {960'd0, len_r};
          end
          pend_s  = PEND_NONE;
          final_s = 1'b1;
          state_s = ST_SEND;
        end else if (open_r) begin
          buf_s   = 1024'd0;
          state_s = ST_FILL;
        end else begin
          state_s = ST_IDLE;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // State, datapath and registered engine-side outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r       <= ST_IDLE;
      pend_r        <= PEND_NONE;
      mode_r        <= sha::sha1;
      buf_r         <= 1024'd0;
      cnt_r         <= {BYTE_CNT_W{1'b0}};
      idx_r         <= 8'd0;
      len_r         <= 64'd0;
      first_r       <= 1'b0;
      final_r       <= 1'b0;
      open_r        <= 1'b0;
      out_valid_r   <= 1'b0;
      out_new_msg_r <= 1'b0;
      out_mode_r    <= sha::sha1;
      out_msg_r     <= 1024'd0;
      msg_done_r    <= 1'b0;
    end else begin
      state_r       <= state_s;
      pend_r        <= pend_s;
      mode_r        <= mode_s;
      buf_r         <= buf_s;
      cnt_r         <= cnt_s;
      idx_r         <= idx_s;
      len_r         <= len_s;
      first_r       <= first_s;
      final_r       <= final_s;
      open_r        <= open_s;
      out_valid_r   <= (state_s == ST_SEND);
      out_new_msg_r <= (state_s == ST_SEND) ? first_s : 1'b0;
      out_mode_r    <= (state_s == ST_SEND) ? mode_s : sha::sha1;
      out_msg_r     <= (state_s == ST_SEND) ? buf_s : 1024'd0;
      msg_done_r    <= msg_done_s;
    end
  end

endmodule
